// File: rtl/receiver.sv
// Serial frame receiver: start bit, 4-bit byte count, payload, CRC-8 and stop bit,
// each bit baudrate clocks long and sampled mid-bit. Publishes a frame only once its stop bit is good.
module receiver #(
  parameter logic [7:0] CRC_POLY = 8'h07,
  parameter logic [7:0] CRC_INIT = 8'h00
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         RX,
  input  logic [7:0]   baudrate,
  output logic         RXI,
  output logic [3:0]   framesize,
  output logic [127:0] framebits,
  output logic [7:0]   crc,
  output logic         rf,
  output logic         crc_err,
  output logic         frame_err
);

  typedef enum logic [2:0] {IDLE, START, SIZE, DATA, CRCF, STOP} state_t;

  state_t         state, next_state;
  logic           armed;
  logic [7:0]     baud;
  logic [7:0]     cnt;
  logic [7:0]     half_tgt;
  logic [7:0]     tgt;
  logic           samp;
  logic [2:0]     bit_cnt;
  logic [3:0]     byte_cnt;
  logic [3:0]     size_sh;
  logic [7:0]     byte_sh;
  logic [7:0]     crc_sh;
  logic [7:0]     crc_calc;
  logic [7:0]     crc_next;
  logic [127:0]   payload;
  logic           commit;

  // START samples floor(B/2) clocks after detection; the counter starts one clock late,
  // so the target is one less (clamped at zero for B = 1).
  assign half_tgt = ((baud >> 1) == 8'd0) ? 8'd0 : (baud >> 1) - 8'd1;
  assign tgt      = (state == START) ? half_tgt : baud - 8'd1;
  assign samp     = (state != IDLE) && (cnt == tgt);
  assign crc_next = {crc_calc[6:0], 1'b0} ^ ((crc_calc[7] ^ RX) ? CRC_POLY : 8'h00);

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= next_state;
  end

  // Next-state logic
  always_comb begin
    next_state = state;
    unique case (state)
      IDLE:  if (armed && RX) next_state = START;
      START: if (samp) next_state = RX ? SIZE : IDLE;
      SIZE:  if (samp && bit_cnt == 3'd3)
               next_state = ({size_sh[2:0], RX} == 4'd0) ? IDLE : DATA;
      DATA:  if (samp && bit_cnt == 3'd7 && byte_cnt == size_sh - 4'd1) next_state = CRCF;
      CRCF:  if (samp && bit_cnt == 3'd7) next_state = STOP;
      STOP:  if (samp) next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  // Output logic
  always_comb begin
    RXI = (state == IDLE);
  end

  // Datapath, counters and published outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      armed     <= 1'b0;
      baud      <= 8'd0;
      cnt       <= 8'd0;
      bit_cnt   <= 3'd0;
      byte_cnt  <= 4'd0;
      size_sh   <= 4'd0;
      byte_sh   <= 8'd0;
      crc_sh    <= 8'd0;
      crc_calc  <= 8'd0;
      payload   <= 128'd0;
      commit    <= 1'b0;
      framesize <= 4'd0;
      framebits <= 128'd0;
      crc       <= 8'd0;
      crc_err   <= 1'b0;
      rf        <= 1'b0;
      frame_err <= 1'b0;
    end else begin
      rf        <= 1'b0;
      frame_err <= 1'b0;
      commit    <= 1'b0;
      // Arming needs a low line seen in IDLE; it is dropped whenever a frame is in progress.
      armed     <= (state == IDLE) && !RX;

      if (state == IDLE) begin
        cnt <= 8'd0;
        if (armed && RX) begin
          baud     <= (baudrate == 8'd0) ? 8'd1 : baudrate;
          bit_cnt  <= 3'd0;
          byte_cnt <= 4'd0;
          size_sh  <= 4'd0;
          payload  <= 128'd0;
          crc_calc <= CRC_INIT;
        end
      end else if (samp) begin
        cnt <= 8'd0;
      end else begin
        cnt <= cnt + 8'd1;
      end

      if (samp) begin
        unique case (state)
          SIZE: begin
            size_sh <= {size_sh[2:0], RX};
            bit_cnt <= (bit_cnt == 3'd3) ? 3'd0 : bit_cnt + 3'd1;
            if (bit_cnt == 3'd3 && {size_sh[2:0], RX} == 4'd0) frame_err <= 1'b1;
          end
          DATA: begin
            byte_sh  <= {byte_sh[6:0], RX};
            crc_calc <= crc_next;
            bit_cnt  <= bit_cnt + 3'd1;
            if (bit_cnt == 3'd7) begin
              payload[{byte_cnt, 3'b000} +: 8] <= {byte_sh[6:0], RX};
              byte_cnt <= byte_cnt + 4'd1;
            end
          end
          CRCF: begin
            crc_sh  <= {crc_sh[6:0], RX};
            bit_cnt <= bit_cnt + 3'd1;
          end
          STOP: begin
            if (RX) commit    <= 1'b1;
            else    frame_err <= 1'b1;
          end
          default: ;
        endcase
      end

      if (commit) begin
        framesize <= size_sh;
        framebits <= payload;
        crc       <= crc_sh;
        crc_err   <= (crc_sh != crc_calc);
        rf        <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_receiver.sv
// Directed bench for receiver: good frames, CRC error, max size, false start,
// zero size, bad stop bit and mid-frame reset.
module tb_receiver;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         RX;
  logic [7:0]   baudrate;
  logic         RXI;
  logic [3:0]   framesize;
  logic [127:0] framebits;
  logic [7:0]   crc;
  logic         rf;
  logic         crc_err;
  logic         frame_err;

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;
  int rf_cnt  = 0;
  int fe_cnt  = 0;
  int both_cnt = 0;
  int rf_cyc  = 0;
  int t0      = 0;
  int rf0, fe0;
  logic [127:0] exp_bits;
  logic [7:0]   exp_crc;

  receiver dut (
    .clk(clk), .rst_n(rst_n), .RX(RX), .baudrate(baudrate), .RXI(RXI),
    .framesize(framesize), .framebits(framebits), .crc(crc), .rf(rf),
    .crc_err(crc_err), .frame_err(frame_err)
  );

  // Clock and pulse monitor
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  always @(negedge clk) begin
    if (rf) begin rf_cnt++; rf_cyc = cyc; end
    if (frame_err) fe_cnt++;
    if (rf && frame_err) both_cnt++;
  end

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h required %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [7:0] crc_byte(input logic [7:0] c_in, input logic [7:0] d);
    logic [7:0] c;
    c = c_in;
    for (int i = 7; i >= 0; i--) begin
      if (c[7] ^ d[i]) c = {c[6:0], 1'b0} ^ 8'h07;
      else             c = {c[6:0], 1'b0};
    end
    return c;
  endfunction

  task automatic step();
    @(posedge clk); #1;
  endtask

  task automatic drive_bit(input logic v, input logic [7:0] b);
    RX = v;
    for (int i = 0; i < int'(b); i++) step();
  endtask

  // Full frame; baudrate input is disturbed after the start bit to show it is latched.
  task automatic send_frame(input logic [7:0] b, input logic [3:0] n, input logic [127:0] data,
                            input logic [7:0] c, input logic stop_v);
    baudrate = b;
    RX = 1'b0;
    for (int i = 0; i < 3; i++) step();
    t0 = cyc;
    drive_bit(1'b1, b);
    baudrate = b + 8'd5;
    for (int i = 3; i >= 0; i--) drive_bit(n[i], b);
    for (int k = 0; k < int'(n); k++)
      for (int i = 7; i >= 0; i--) drive_bit(data[8*k+i], b);
    for (int i = 7; i >= 0; i--) drive_bit(c[i], b);
    drive_bit(stop_v, b);
    RX = 1'b0;
    for (int i = 0; i < 8; i++) step();
  endtask

  initial begin
    rst_n = 1'b0;
    RX = 1'b0;
    baudrate = 8'd4;
    for (int i = 0; i < 3; i++) step();
    check("reset_rxi", 128'(RXI), 128'd1);
    check("reset_rf", 128'(rf), 128'd0);
    check("reset_frame_err", 128'(frame_err), 128'd0);
    check("reset_framesize", 128'(framesize), 128'd0);
    check("reset_framebits", framebits, 128'd0);
    check("reset_crc", 128'(crc), 128'd0);
    check("reset_crc_err", 128'(crc_err), 128'd0);
    rst_n = 1'b1;
    step();

    // Frame A: one byte 01, correct CRC 07
    rf0 = rf_cnt; fe0 = fe_cnt;
    send_frame(8'd4, 4'd1, 128'h01, 8'h07, 1'b1);
    check("a_rf_count", 128'(rf_cnt - rf0), 128'd1);
    check("a_fe_count", 128'(fe_cnt - fe0), 128'd0);
    check("a_framesize", 128'(framesize), 128'd1);
    check("a_framebits", framebits, 128'h01);
    check("a_crc", 128'(crc), 128'h07);
    check("a_crc_err", 128'(crc_err), 128'd0);
    check("a_latency", 128'((rf_cyc - t0) >= 88 && (rf_cyc - t0) <= 90), 128'd1);
    check("a_rxi", 128'(RXI), 128'd1);

    // Frame B: same byte, wrong CRC field
    rf0 = rf_cnt;
    send_frame(8'd4, 4'd1, 128'h01, 8'h00, 1'b1);
    check("b_rf_count", 128'(rf_cnt - rf0), 128'd1);
    check("b_crc", 128'(crc), 128'h00);
    check("b_crc_err", 128'(crc_err), 128'd1);

    // Frame C: 15 bytes 00..0E at baudrate 8
    exp_bits = 128'd0;
    exp_crc = 8'h00;
    for (int k = 0; k < 15; k++) begin
      exp_bits[8*k +: 8] = 8'(k);
      exp_crc = crc_byte(exp_crc, 8'(k));
    end
    rf0 = rf_cnt;
    send_frame(8'd8, 4'd15, exp_bits, exp_crc, 1'b1);
    check("c_rf_count", 128'(rf_cnt - rf0), 128'd1);
    check("c_framesize", 128'(framesize), 128'd15);
    check("c_framebits", framebits, exp_bits);
    check("c_crc", 128'(crc), 128'(exp_crc));
    check("c_crc_err", 128'(crc_err), 128'd0);

    // False start: line high for only two clocks
    rf0 = rf_cnt; fe0 = fe_cnt;
    baudrate = 8'd8;
    RX = 1'b0;
    for (int i = 0; i < 3; i++) step();
    RX = 1'b1;
    step(); step();
    RX = 1'b0;
    for (int i = 0; i < 30; i++) step();
    check("fs_rf_count", 128'(rf_cnt - rf0), 128'd0);
    check("fs_fe_count", 128'(fe_cnt - fe0), 128'd0);
    check("fs_rxi", 128'(RXI), 128'd1);

    // Zero framesize on the line
    fe0 = fe_cnt; rf0 = rf_cnt;
    for (int i = 0; i < 3; i++) step();
    drive_bit(1'b1, 8'd8);
    for (int i = 0; i < 4; i++) drive_bit(1'b0, 8'd8);
    for (int i = 0; i < 20; i++) step();
    check("z_fe_count", 128'(fe_cnt - fe0), 128'd1);
    check("z_rf_count", 128'(rf_cnt - rf0), 128'd0);
    check("z_framesize", 128'(framesize), 128'd15);
    check("z_framebits", framebits, exp_bits);

    // Bad stop bit
    fe0 = fe_cnt; rf0 = rf_cnt;
    send_frame(8'd4, 4'd1, 128'hAA, crc_byte(8'h00, 8'hAA), 1'b0);
    check("s_fe_count", 128'(fe_cnt - fe0), 128'd1);
    check("s_rf_count", 128'(rf_cnt - rf0), 128'd0);
    check("s_framesize", 128'(framesize), 128'd15);
    check("s_framebits", framebits, exp_bits);
    check("s_crc", 128'(crc), 128'(exp_crc));

    // Reset during DATA
    fe0 = fe_cnt; rf0 = rf_cnt;
    baudrate = 8'd4;
    RX = 1'b0;
    for (int i = 0; i < 3; i++) step();
    drive_bit(1'b1, 8'd4);
    drive_bit(1'b0, 8'd4); drive_bit(1'b0, 8'd4); drive_bit(1'b1, 8'd4); drive_bit(1'b0, 8'd4);
    for (int i = 0; i < 5; i++) drive_bit(1'b1, 8'd4);
    check("r_busy_before", 128'(RXI), 128'd0);
    rst_n = 1'b0;
    #1;
    check("r_rxi", 128'(RXI), 128'd1);
    check("r_framesize", 128'(framesize), 128'd0);
    check("r_framebits", framebits, 128'd0);
    check("r_crc", 128'(crc), 128'd0);
    check("r_crc_err", 128'(crc_err), 128'd0);
    RX = 1'b0;
    for (int i = 0; i < 4; i++) step();
    rst_n = 1'b1;
    for (int i = 0; i < 10; i++) step();
    check("r_no_pulses", 128'((rf_cnt - rf0) + (fe_cnt - fe0)), 128'd0);
    send_frame(8'd4, 4'd1, 128'h01, 8'h07, 1'b1);
    check("r_next_rf", 128'(rf_cnt - rf0), 128'd1);
    check("r_next_framebits", framebits, 128'h01);
    check("r_next_crc_err", 128'(crc_err), 128'd0);

    check("never_rf_and_fe", 128'(both_cnt), 128'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/receiver.md
RECEIVER -- requirements
Module: receiver

Interface
REQ-001 Parameter CRC_POLY, default 8'h07, CRC-8 generator polynomial (x^8+x^2+x+1, implicit x^8).
REQ-002 Parameter CRC_INIT, default 8'h00, CRC register value at start of each frame.
REQ-003 clk  input  1  system clock; all state changes on rising edge.
REQ-004 rst_n  input  1  reset; asynchronous, active-low.
REQ-005 RX  input  1  serial line, driven by the transmitter's TX, synchronous to clk.
REQ-006 baudrate  input  8  clocks per bit; sampled only at start-bit detection.
REQ-007 RXI  output  1  idle indicator; 1 when no frame is in progress.
REQ-008 framesize  output  4  received byte count of last good-format frame.
REQ-009 framebits  output  128  received payload; byte k at bits [8k+7:8k].
REQ-010 crc  output  8  CRC field as received.
REQ-011 rf  output  1  one-cycle pulse: frame complete, outputs valid.
REQ-012 crc_err  output  1  valid with rf; 1 = received crc differs from computed CRC.
REQ-013 frame_err  output  1  one-cycle pulse: framing error, frame discarded.

Function
REQ-014 The line format SHALL be: idle 0; start bit 1; framesize 4 bits MSB first; framesize bytes, byte 0 first, each MSB first; crc 8 bits MSB first; stop bit 1; every bit baudrate clocks long.
REQ-015 The FSM SHALL have states IDLE, START, SIZE, DATA, CRCF, STOP; RXI = 1 only in IDLE.
REQ-016 IDLE SHALL arm only after sampling RX = 0 for at least one cycle; an armed IDLE seeing RX = 1 SHALL latch baudrate (0 treated as 1), clear the baud counter, and enter START.
REQ-017 START SHALL resample RX at offset floor(B/2) cycles after detection (B = latched baudrate); RX = 0 -> IDLE (false start, no pulse); RX = 1 -> SIZE.
REQ-018 Each subsequent bit SHALL be sampled exactly B cycles after the previous sample (mid-bit).
REQ-019 SIZE SHALL shift in 4 bits; received value 0 -> frame_err pulse, IDLE; otherwise -> DATA.
REQ-020 DATA SHALL shift in 8*framesize bits using a 3-bit bit counter and 4-bit byte counter, writing each completed byte to slot byte-counter; then -> CRCF.
REQ-021 The CRC SHALL be computed serially over DATA bits only, in line order, MSB-first shift, init CRC_INIT, no reflection, no final XOR.
REQ-022 CRCF SHALL shift in 8 bits, then -> STOP.
REQ-023 STOP sample RX = 1 SHALL, on the following cycle, update framesize, framebits (unused bytes zero), crc, crc_err and pulse rf for one cycle, then -> IDLE disarmed.
REQ-024 STOP sample RX = 0 SHALL pulse frame_err for one cycle, leave outputs unchanged, -> IDLE disarmed.
REQ-025 framesize, framebits, crc, crc_err SHALL hold their values between rf pulses; partial frames SHALL never alter them.
REQ-026 rf and frame_err SHALL never be asserted in the same cycle.
REQ-027 baudrate changes mid-frame SHALL have no effect until the next start detection.

Reset
REQ-028 rst_n = 0 SHALL immediately force IDLE disarmed, RXI = 1, rf = 0, frame_err = 0, crc_err = 0, framesize = 0, framebits = 0, crc = 0, all counters 0.
REQ-029 Reset asserted mid-frame SHALL discard the frame with no rf or frame_err pulse.

Verification
REQ-030 baudrate 4, frame framesize 1, byte 8'h01, crc 8'h07, stop 1 -> rf pulse once, framesize 1, framebits[7:0] = 8'h01, rest 0, crc 8'h07, crc_err 0; rf 89 cycles after start edge (±1).
REQ-031 Same frame with crc field 8'h00 -> rf pulse, crc 8'h00, crc_err 1.
REQ-032 baudrate 8, framesize 15, bytes 8'h00..8'h0E, correct CRC -> framebits byte k = k for k = 0..14, byte 15 = 0, crc_err 0.
REQ-033 RX high for 2 cycles then low, baudrate 8 -> no rf, no frame_err, RXI returns 1; framesize 0 on line -> frame_err pulse, outputs unchanged.
REQ-034 Valid frame with stop bit 0 -> frame_err pulse, outputs keep prior values; rst_n pulsed low during DATA -> RXI 1, all outputs 0, no pulses, next valid frame received correctly.
